// File: rtl/coverfloat_event_counter_if.sv
// ---------------------------------------------------------------------------
// coverfloat_event_counter_if
//
// Purpose: groups the record stream, the clear/read control and the read
// return of the coverfloat coverage counter bank into one bundle.
//
// Signals:
//   in_valid / in_ready   record stream handshake
//   in_op, in_rm,         operation code, rounding mode, SoftFloat flag byte
//   in_flags
//   clr_req               single-cycle pulse, starts a clear sweep
//   rd_req, rd_addr       snapshot read request and counter address
//   rd_valid, rd_data     snapshot read return, one cycle after rd_req
//
// Modports: master drives records and requests, slave is the counter bank.
// ---------------------------------------------------------------------------
interface coverfloat_event_counter_if #(
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_op;
    logic [7:0]        in_rm;
    logic [7:0]        in_flags;
    logic              clr_req;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;

    modport master (
        output in_valid, in_op, in_rm, in_flags, clr_req, rd_req, rd_addr,
        input  in_ready, rd_valid, rd_data
    );

    modport slave (
        input  in_valid, in_op, in_rm, in_flags, clr_req, rd_req, rd_addr,
        output in_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/coverfloat_event_counter.sv
// ---------------------------------------------------------------------------
// coverfloat_event_counter
//
// Purpose: per-operation coverage counter bank. Each accepted result record
// bumps the "total" counter of its operation row plus one counter per set
// SoftFloat exception flag. A row-sequential clear sweep and a one-cycle
// snapshot read port let the harvester collect coverage.
//
// Parameters:
//   NUM_OPS  number of operation codes (1..NUM_OPS are valid)
//   CNT_W    counter width (>= 2)
//   SAT      1: counters saturate at all-ones, 0: counters wrap to 0
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   bus          slave side of coverfloat_event_counter_if
//   busy         FSM not in IDLE
//   sat_seen     sticky: some counter saturated / wrapped
//   bad_op       sticky: an accepted record carried op 0 or op > NUM_OPS
//   dbg_state_o  current FSM state (0 IDLE, 1 CLEAR, 2 READ)
//
// Address map (row r = op-1): r*6+0 total, r*6+1+b flag bit b (b=0..4),
// NUM_OPS*6+m rounding-mode counter m. Other addresses read 0.
//
// Optional feature: define COVERFLOAT_RM_BINS_EN to build the six
// rounding-mode counters; without it in_rm is ignored and those
// addresses read 0.
//
// Handshake: a record transfers on a rising edge where in_valid && in_ready.
// in_ready is combinational and is high only in IDLE with no clr_req, no
// rd_req and no reset; the source must hold the record stable until it
// transfers. in_valid may be raised without waiting for in_ready.
// ---------------------------------------------------------------------------
module coverfloat_event_counter #(
    parameter int NUM_OPS = 13,
    parameter int CNT_W   = 16,
    parameter int SAT     = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    coverfloat_event_counter_if.slave        bus,
    output logic                             busy,
    output logic                             sat_seen,
    output logic                             bad_op,
    output logic [1:0]                       dbg_state_o
);
    localparam int ADDR_W = $clog2(NUM_OPS*6+6);
    localparam int ROW_W  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CNT_W-1:0]   cnt_q [NUM_OPS][6];
    logic               rd_valid_q;
    logic [CNT_W-1:0]   rd_data_q;
    logic               sat_q;
    logic               bad_q;

    logic               in_ready_c;
    logic               start_clear;
    logic               start_read;
    logic               accept;
    logic               op_ok;
    logic [5:0]         hit_mask;
    logic [NUM_OPS-1:0] row_hit;
    logic               sat_evt;
    logic [CNT_W-1:0]   rd_lookup;
    logic               unused_inputs;

`ifdef COVERFLOAT_RM_BINS_EN
    logic [CNT_W-1:0]   rm_q [6];
    logic [5:0]         rm_hit;
    assign unused_inputs = ^bus.in_flags[7:5];
`else
    assign unused_inputs = ^{bus.in_flags[7:5], bus.in_rm};
`endif

    // One increment step; at all-ones either hold or wrap.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if (&v) bump = (SAT != 0) ? v : '0;
        else    bump = v + CNT_W'(1);
    endfunction

    // Next-state / handshake decode.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        in_ready_c  = 1'b0;
        start_clear = 1'b0;
        start_read  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d     = CLEAR;
                    start_clear = 1'b1;
                    row_d       = '0;
                end else if (bus.rd_req) begin
                    state_d    = READ;
                    start_read = 1'b1;
                end else begin
                    in_ready_c = !reset;
                end
            end
            CLEAR: begin
                if (row_q == ROW_W'(NUM_OPS-1)) begin
                    state_d = IDLE;
                    row_d   = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            READ:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept   = bus.in_valid && in_ready_c;
    assign op_ok    = (bus.in_op != 8'd0) && (bus.in_op <= 8'(NUM_OPS));
    // Column 0 (total) always counts; columns 1..5 follow flag bits 0..4.
    assign hit_mask = {bus.in_flags[4:0], 1'b1};

    // Increment enables and saturation detect for the accepted record.
    always_comb begin
        row_hit = '0;
        sat_evt = 1'b0;
        for (int r = 0; r < NUM_OPS; r++) begin
            row_hit[r] = accept && op_ok && (bus.in_op == 8'(r+1));
            for (int c = 0; c < 6; c++) begin
                if (row_hit[r] && hit_mask[c] && (&cnt_q[r][c])) sat_evt = 1'b1;
            end
        end
`ifdef COVERFLOAT_RM_BINS_EN
        rm_hit = '0;
        for (int m = 0; m < 6; m++) begin
            rm_hit[m] = accept && op_ok && (bus.in_rm == 8'(m));
            if (rm_hit[m] && (&rm_q[m])) sat_evt = 1'b1;
        end
`endif
    end

    // Snapshot mux; anything unmapped reads 0.
    always_comb begin
        rd_lookup = '0;
        for (int r = 0; r < NUM_OPS; r++) begin
            for (int c = 0; c < 6; c++) begin
                if (bus.rd_addr == ADDR_W'(r*6+c)) rd_lookup = cnt_q[r][c];
            end
        end
`ifdef COVERFLOAT_RM_BINS_EN
        for (int m = 0; m < 6; m++) begin
            if (bus.rd_addr == ADDR_W'(NUM_OPS*6+m)) rd_lookup = rm_q[m];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            sat_q      <= 1'b0;
            bad_q      <= 1'b0;
            for (int r = 0; r < NUM_OPS; r++) begin
                for (int c = 0; c < 6; c++) cnt_q[r][c] <= '0;
            end
`ifdef COVERFLOAT_RM_BINS_EN
            for (int m = 0; m < 6; m++) rm_q[m] <= '0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            rd_valid_q <= start_read;
            // The address is used on the request edge; the value seen then
            // already includes every earlier accept.
            if (start_read) rd_data_q <= rd_lookup;

            if (start_clear) begin
                sat_q <= 1'b0;
                bad_q <= 1'b0;
            end else begin
                if (sat_evt)          sat_q <= 1'b1;
                if (accept && !op_ok) bad_q <= 1'b1;
            end

            for (int r = 0; r < NUM_OPS; r++) begin
                for (int c = 0; c < 6; c++) begin
                    if (state_q == CLEAR && row_q == ROW_W'(r))
                        cnt_q[r][c] <= '0;
                    else if (row_hit[r] && hit_mask[c])
                        cnt_q[r][c] <= bump(cnt_q[r][c]);
                end
            end
`ifdef COVERFLOAT_RM_BINS_EN
            // Rounding-mode bins are swept together with row 0.
            for (int m = 0; m < 6; m++) begin
                if (state_q == CLEAR && row_q == '0)
                    rm_q[m] <= '0;
                else if (rm_hit[m])
                    rm_q[m] <= bump(rm_q[m]);
            end
`endif
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign busy         = (state_q != IDLE);
    assign sat_seen     = sat_q;
    assign bad_op       = bad_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_coverfloat_event_counter.sv
// ---------------------------------------------------------------------------
// tb_coverfloat_event_counter
//
// Bench for coverfloat_event_counter. One full-width instance plus two
// CNT_W=2 instances (SAT=1 and SAT=0) that see the same stimulus, so the
// saturating and wrapping behaviour is checked against the same count model.
// ---------------------------------------------------------------------------
module tb_coverfloat_event_counter;
    localparam int NUM_OPS = 13;
    localparam int ADDR_W  = 7;
    localparam int CNT_W   = 16;
    localparam int RM_BASE = NUM_OPS*6;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    coverfloat_event_counter_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) m_if ();
    coverfloat_event_counter_if #(.ADDR_W(ADDR_W), .CNT_W(2))     s1_if ();
    coverfloat_event_counter_if #(.ADDR_W(ADDR_W), .CNT_W(2))     s0_if ();

    assign s1_if.in_valid = m_if.in_valid;
    assign s1_if.in_op    = m_if.in_op;
    assign s1_if.in_rm    = m_if.in_rm;
    assign s1_if.in_flags = m_if.in_flags;
    assign s1_if.clr_req  = m_if.clr_req;
    assign s1_if.rd_req   = m_if.rd_req;
    assign s1_if.rd_addr  = m_if.rd_addr;
    assign s0_if.in_valid = m_if.in_valid;
    assign s0_if.in_op    = m_if.in_op;
    assign s0_if.in_rm    = m_if.in_rm;
    assign s0_if.in_flags = m_if.in_flags;
    assign s0_if.clr_req  = m_if.clr_req;
    assign s0_if.rd_req   = m_if.rd_req;
    assign s0_if.rd_addr  = m_if.rd_addr;

    logic       busy, sat_seen, bad_op;
    logic [1:0] dbg_state;
    logic       s1_busy, s1_sat, s1_bad;
    logic [1:0] s1_state;
    logic       s0_busy, s0_sat, s0_bad;
    logic [1:0] s0_state;

    coverfloat_event_counter #(.NUM_OPS(NUM_OPS), .CNT_W(CNT_W), .SAT(1)) dut (
        .clk(clk), .reset(reset), .bus(m_if), .busy(busy),
        .sat_seen(sat_seen), .bad_op(bad_op), .dbg_state_o(dbg_state)
    );
    coverfloat_event_counter #(.NUM_OPS(NUM_OPS), .CNT_W(2), .SAT(1)) dut_s1 (
        .clk(clk), .reset(reset), .bus(s1_if), .busy(s1_busy),
        .sat_seen(s1_sat), .bad_op(s1_bad), .dbg_state_o(s1_state)
    );
    coverfloat_event_counter #(.NUM_OPS(NUM_OPS), .CNT_W(2), .SAT(0)) dut_s0 (
        .clk(clk), .reset(reset), .bus(s0_if), .busy(s0_busy),
        .sat_seen(s0_sat), .bad_op(s0_bad), .dbg_state_o(s0_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int exp_cnt [NUM_OPS][6];
    int exp_rm  [6];
    bit exp_bad;

    task automatic model_clear();
        for (int r = 0; r < NUM_OPS; r++)
            for (int c = 0; c < 6; c++) exp_cnt[r][c] = 0;
        for (int m = 0; m < 6; m++) exp_rm[m] = 0;
        exp_bad = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] op, input logic [7:0] rm, input logic [7:0] flags);
        if (op == 8'd0 || op > 8'(NUM_OPS)) begin
            exp_bad = 1'b1;
        end else begin
            exp_cnt[op-1][0]++;
            for (int b = 0; b < 5; b++) if (flags[b]) exp_cnt[op-1][b+1]++;
`ifdef COVERFLOAT_RM_BINS_EN
            if (rm <= 8'd5) exp_rm[rm]++;
`else
            if (rm > 8'd255) exp_bad = 1'b1;  // rm has no effect without rm bins
`endif
        end
    endtask

    function automatic int model_count(input int addr);
        if (addr < RM_BASE) return exp_cnt[addr/6][addr%6];
`ifdef COVERFLOAT_RM_BINS_EN
        if (addr < RM_BASE+6) return exp_rm[addr-RM_BASE];
`endif
        return 0;
    endfunction

    // A 2-bit counter overflows once any count since clear reaches 4.
    function automatic logic model_wrapped();
        for (int a = 0; a < RM_BASE+6; a++) if (model_count(a) >= 4) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- scoreboard ----------------
    logic [CNT_W-1:0] exp_q[$];
    logic [1:0]       exp_s1_q[$];
    logic [1:0]       exp_s0_q[$];
    int               addr_q[$];

    task automatic push_exp(input int addr);
        int n;
        n = model_count(addr);
        exp_q.push_back(CNT_W'(n));
        exp_s1_q.push_back((n > 3) ? 2'd3 : 2'(n));
        exp_s0_q.push_back(2'(n));
        addr_q.push_back(addr);
    endtask

    always @(posedge clk) begin
        #2;
        if (m_if.rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_spurious", m_if.rd_valid, 1'b0);
            end else begin
                int a;
                a = addr_q.pop_front();
                check($sformatf("rd_data@%0d", a), m_if.rd_data, exp_q.pop_front());
                check($sformatf("s1_data@%0d", a), s1_if.rd_data, exp_s1_q.pop_front());
                check($sformatf("s0_data@%0d", a), s0_if.rd_data, exp_s0_q.pop_front());
                check("s1_rd_valid", s1_if.rd_valid, 1'b1);
                check("s0_rd_valid", s0_if.rd_valid, 1'b1);
            end
        end
    end

    // ---------------- drivers (entered and left on a negedge) ----------------
    task automatic send(input logic [7:0] op, input logic [7:0] rm, input logic [7:0] flags);
        bit done;
        done = 1'b0;
        m_if.in_valid = 1'b1;
        m_if.in_op    = op;
        m_if.in_rm    = rm;
        m_if.in_flags = flags;
        for (int i = 0; i < 64 && !done; i++) begin
            #1;
            if (m_if.in_ready) begin
                done = 1'b1;
                model_accept(op, rm, flags);
            end
            @(negedge clk);
        end
        m_if.in_valid = 1'b0;
        check("send_accept", done, 1'b1);
    endtask

    task automatic read(input int addr);
        m_if.rd_req  = 1'b1;
        m_if.rd_addr = ADDR_W'(addr);
        push_exp(addr);
        #1 check("rdreq_ready", m_if.in_ready, 1'b0);
        @(negedge clk);
        check("rd_valid_hi", m_if.rd_valid, 1'b1);
        check("rd_busy", busy, 1'b1);
        check("rd_state", dbg_state, 2'd2);
        check("rd_ready", m_if.in_ready, 1'b0);
        m_if.rd_req = 1'b0;
        @(negedge clk);
        check("rd_valid_lo", m_if.rd_valid, 1'b0);
        check("rd_busy_lo", busy, 1'b0);
    endtask

    task automatic read_all();
        for (int a = 0; a < (1 << ADDR_W); a++) read(a);
    endtask

    task automatic do_clear(input bit with_rd);
        m_if.clr_req = 1'b1;
        m_if.rd_req  = with_rd;
        m_if.rd_addr = '0;
        #1 check("clr_ready", m_if.in_ready, 1'b0);
        @(negedge clk);
        m_if.clr_req = 1'b0;
        m_if.rd_req  = 1'b0;
        model_clear();
        for (int i = 0; i < NUM_OPS; i++) begin
            check("clr_busy", busy, 1'b1);
            check("clr_ready_lo", m_if.in_ready, 1'b0);
            @(negedge clk);
        end
        check("clr_done_busy", busy, 1'b0);
        check("clr_bad", bad_op, 1'b0);
        check("clr_sat", sat_seen, 1'b0);
        check("clr_s1_sat", s1_sat, 1'b0);
        check("clr_s0_sat", s0_sat, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        m_if.in_valid = 1'b1;   // offered during reset, must not count
        m_if.in_op    = 8'd1;
        m_if.in_rm    = 8'd0;
        m_if.in_flags = 8'h1f;
        m_if.clr_req  = 1'b0;
        m_if.rd_req   = 1'b0;
        m_if.rd_addr  = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check("reset_ready", m_if.in_ready, 1'b0);
        m_if.in_valid = 1'b0;
        reset = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        check("rst_rd_valid", m_if.rd_valid, 1'b0);
        check("rst_rd_data", m_if.rd_data, 16'd0);
        check("rst_sat", sat_seen, 1'b0);
        check("rst_bad", bad_op, 1'b0);
        #1 check("rst_ready_after", m_if.in_ready, 1'b1);
        @(negedge clk);

        // First read after reset, then records of MUL with inexact+overflow.
        read(0);
        for (int i = 0; i < 3; i++) send(8'd3, 8'd0, 8'h05);
        for (int a = 12; a <= 17; a++) read(a);

        // Saturate / wrap the narrow instances.
        do_clear(1'b0);
        for (int i = 0; i < 5; i++) send(8'd1, 8'd0, 8'h00);
        read(0);
        read(1);
        check("main_sat", sat_seen, 1'b0);
        check("s1_sat", s1_sat, model_wrapped());
        check("s0_sat", s0_sat, model_wrapped());

        // Illegal op codes, then clear with a colliding read request.
        do_clear(1'b0);
        send(8'd0, 8'd0, 8'h1f);
        send(8'd14, 8'd1, 8'h1f);
        check("bad_op_set", bad_op, exp_bad);
        read(0);
        read(72);
        read(77);
        do_clear(1'b1);

        // Random records with interleaved reads.
        for (int i = 0; i < 60; i++) begin
            send(8'($urandom_range(0, 14)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) read($urandom_range(0, 127));
        end
        check("rand_bad", bad_op, exp_bad);
        check("rand_s1_sat", s1_sat, model_wrapped());
        read_all();

        // Clear with a record held and a read request in the middle of the sweep.
        m_if.in_valid = 1'b1;
        m_if.in_op    = 8'd5;
        m_if.in_rm    = 8'd1;
        m_if.in_flags = 8'h12;
        m_if.clr_req  = 1'b1;
        #1 check("hold_clr_ready", m_if.in_ready, 1'b0);
        @(negedge clk);
        m_if.clr_req = 1'b0;
        model_clear();
        for (int i = 1; i <= NUM_OPS; i++) begin
            if (i == 5) begin m_if.rd_req = 1'b1; m_if.rd_addr = 7'd24; end
            if (i == 6) m_if.rd_req = 1'b0;
            check("hold_busy", busy, 1'b1);
            #1 check("hold_ready", m_if.in_ready, 1'b0);
            @(negedge clk);
        end
        #1 check("hold_first_idle", m_if.in_ready, 1'b1);
        model_accept(8'd5, 8'd1, 8'h12);
        @(negedge clk);
        m_if.in_valid = 1'b0;
        read_all();

        // Rounding-mode bins (read 0 when not built).
        do_clear(1'b0);
        send(8'd2, 8'd0, 8'h00);
        send(8'd2, 8'd0, 8'h01);
        send(8'd7, 8'd4, 8'h00);
        send(8'd7, 8'd7, 8'h00);
        for (int a = RM_BASE; a < RM_BASE+6; a++) read(a);
        read(6);
        read(36);

        // Reset in the middle of a clear sweep.
        m_if.clr_req = 1'b1;
        @(negedge clk);
        m_if.clr_req = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_clr_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_clr_idle", dbg_state, 2'd0);
        check("mid_clr_ready", m_if.in_ready, 1'b0);
        reset = 1'b0;
        model_clear();
        read_all();

        // Reset during a read.
        send(8'd4, 8'd2, 8'h08);
        m_if.rd_req  = 1'b1;
        m_if.rd_addr = 7'd18;
        push_exp(18);
        @(negedge clk);
        m_if.rd_req = 1'b0;
        check("mid_rd_valid", m_if.rd_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rd_valid_lo", m_if.rd_valid, 1'b0);
        check("mid_rd_busy", busy, 1'b0);
        reset = 1'b0;
        model_clear();
        read(18);
        read(21);

        repeat (3) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/coverfloat_event_counter.md
# coverfloat_event_counter

Per-operation coverage counter bank for the floating-point coverage flow. It consumes one result record per cycle over a valid/ready stream: an IBM-paper operation code, a SoftFloat rounding mode and a SoftFloat exception-flag byte. For each record it increments saturating counters indexed by operation and flag. A row-sequential clear FSM and a single-cycle snapshot read port let the testbench harvest coverage without stopping the stream for long.

## Interface
- NUM_OPS, 13: operation codes accepted, 1..NUM_OPS (ADD=1 … CLASS=13).
- CNT_W, 16: counter width, minimum 2.
- SAT, 1: 1 = counters saturate at all-ones; 0 = counters wrap to 0.
- ADDR_W, derived: $clog2(NUM_OPS*6+6); read address width.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  record present.
- in_ready  out  1  record accepted when in_valid && in_ready.
- in_op  in  8  operation code (low byte of the 32-bit op encoding).
- in_rm  in  8  rounding mode, 0..5 (NEAR_EVEN … ODD).
- in_flags  in  8  SoftFloat flags: bit0 inexact, bit1 underflow, bit2 overflow, bit3 infinite, bit4 invalid; bits 7:5 ignored.
- clr_req  in  1  single-cycle pulse; starts a clear sweep.
- rd_req  in  1  read request.
- rd_addr  in  ADDR_W  counter address.
- rd_valid  out  1  rd_data valid.
- rd_data  out  CNT_W  counter value.
- busy  out  1  FSM not in IDLE.
- sat_seen  out  1  sticky: some counter hit all-ones (SAT=1) or wrapped (SAT=0).
- bad_op  out  1  sticky: an accepted record had in_op==0 or in_op>NUM_OPS.

## Operation
- Address map, with row r = in_op-1:
  - addr r*6+0: total records for the op.
  - addr r*6+1+b: records with flag bit b set, b=0..4.
  - addr NUM_OPS*6+m: rounding-mode counter m (only when the configuration macro below is defined).
  - Any other address reads 0.
- FSM states IDLE, CLEAR, READ.
- IDLE priority: clr_req > rd_req > stream.
  - in_ready = (state==IDLE) && !clr_req && !rd_req && !reset. This is combinational.
- Accept:
  - Valid op: the total counter plus every flag counter whose bit is set increment in the same edge.
  - Invalid op: record is consumed, no counter changes, bad_op is set.
  - in_rm > 5: only the rm counter is skipped.
- IDLE→CLEAR on clr_req.
  - CLEAR zeroes one row (6 counters) per cycle, row 0 first, using an internal row counter.
  - The rm counters are zeroed with row 0.
  - After row NUM_OPS-1 the FSM returns to IDLE.
  - Sweep length is NUM_OPS cycles. sat_seen and bad_op are also cleared.
  - clr_req and rd_req asserted during CLEAR are ignored.
- IDLE→READ on rd_req (with no clr_req in the same cycle).
  - rd_addr is latched.
  - In READ: rd_valid=1 and rd_data shows the counter value. The value includes every record accepted before the rd_req cycle.
  - READ→IDLE unconditionally. Back-to-back reads therefore cost 2 cycles each.
- Saturation:
  - SAT=1: a counter at 2^CNT_W-1 holds its value; sat_seen is set on the attempted increment.
  - SAT=0: the counter wraps to 0; sat_seen is set.

## Timing
- Reset values: state IDLE, all counters 0, row counter 0, rd_valid 0, rd_data 0, busy 0, sat_seen 0, bad_op 0. in_ready is 0 while reset is high.
- Reset asserted mid-CLEAR or mid-READ: the FSM returns to IDLE next edge, all counters are zero, and rd_valid is 0.
- Accept-to-count latency is 1 edge. A read requested in the cycle after an accept sees that accept.
- Read latency: rd_valid rises exactly 1 cycle after the rd_req cycle and is high for exactly 1 cycle.
- clr_req in the same cycle as in_valid: the record is not accepted (in_ready=0) and must be held by the source.
- clr_req and rd_req in the same cycle: clear wins and the read is dropped.
- busy equals (state!=IDLE) and is registered.

## Configuration
- COVERFLOAT_RM_BINS_EN defined: six rounding-mode counters exist at addresses NUM_OPS*6+0..5. They are incremented on every accepted record with a valid op and in_rm ≤ 5.
- Not defined: no rm counters are synthesised, those addresses read 0, and in_rm is ignored.

## Test plan
- Reset, then rd_addr=0 → rd_valid one cycle later, rd_data=0, busy=1 for exactly that cycle. in_ready=0 in the read cycle.
- Stream 3 records {op=3 MUL, flags=8'h05} back-to-back → addr 12=3, addr 13=3, addr 15=3, addr 14=0, addr 16=0.
- CNT_W=2, SAT=1: 5 records of op=1, flags=0 → addr 0=3 and sat_seen=1. Rerun with SAT=0 → addr 0=1, sat_seen=1.
- Record op=0 then op=14 (NUM_OPS=13) → both accepted, bad_op=1, all counters 0. clr_req → busy for 13 cycles, then bad_op=0.
- Fill counters, pulse clr_req with in_valid held high and rd_req asserted mid-sweep → no accept for 13 cycles, rd_req ignored, all reads 0 afterwards. The held record is accepted on the first IDLE cycle.
- With COVERFLOAT_RM_BINS_EN: records with rm=0,0,4 and a 7 → addr 78=2, addr 82=1. Assert reset mid-CLEAR → IDLE next cycle, all counters 0.
